// File: rtl/rule_sequencer_pkg.sv
// Shared types and constants for the fuzzy rule sequencer: FSM state
// encoding, rule-base dimensions, the default consequent table and the
// one-hot output-register write strobes.
package rule_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CLR  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } seq_state_t;

  localparam int NUM_SETS  = 3;
  localparam int NUM_RULES = 9;

  // Consequent c(i,j) packed by rule number r = 3*i + j, entry r at bits [2r+1:2r].
  // c = 0 when i+j <= 1, 1 when i+j == 2, 2 when i+j >= 3.
  localparam logic [2*NUM_RULES-1:0] DEFAULT_TABLE = {
    2'd2, 2'd2, 2'd1,   // rules 8,7,6 : (2,2) (2,1) (2,0)
    2'd2, 2'd1, 2'd0,   // rules 5,4,3 : (1,2) (1,1) (1,0)
    2'd1, 2'd0, 2'd0    // rules 2,1,0 : (0,2) (0,1) (0,0)
  };

  localparam logic [3:0] POS_NONE   = 4'b0000;
  localparam logic [3:0] POS_SAIDA0 = 4'b0001;
  localparam logic [3:0] POS_SAIDA1 = 4'b0010;
  localparam logic [3:0] POS_SAIDA2 = 4'b0100;

  // Write strobe for a consequent; code 3 never reaches here, it is folded onto saida_2.
  function automatic logic [3:0] pos_onehot(input logic [1:0] c);
    logic [3:0] v;
    case (c)
      2'd0:    v = POS_SAIDA0;
      2'd1:    v = POS_SAIDA1;
      default: v = POS_SAIDA2;
    endcase
    return v;
  endfunction

  // Default consequent for a rule number; out-of-range numbers read as 0.
  function automatic logic [1:0] default_cons(input logic [3:0] idx);
    logic [1:0] v;
    v = 2'd0;
    if (idx < 4'(NUM_RULES)) v = DEFAULT_TABLE[{idx, 1'b0} +: 2];
    return v;
  endfunction

  // Rule number 3*i + j.
  function automatic logic [3:0] rule_num(input logic [1:0] i, input logic [1:0] j);
    return {1'b0, i, 1'b0} + {2'b00, i} + {2'b00, j};
  endfunction

endpackage

// File: rtl/rule_sequencer_if.sv
// Control bundle between the system controller (master) and the rule
// sequencer (slave), plus the sequencer's drive toward the rule unit.
//
// Handshake: the master raises start for one or more cycles; it is sampled
// only while the sequencer is idle (busy=0, done=0). busy stays high for the
// whole clear+run phase, then done pulses for exactly one cycle with busy=0.
// A start seen while busy or during the done cycle is dropped, not queued.
interface rule_sequencer_if;
  import rule_seq_pkg::*;

  logic       start;
  logic       busy;
  logic       done;
  logic       acc_clr;
  logic [1:0] sel_2;
  logic [1:0] sel_1;
  logic [1:0] Mux_8Canais;
  logic [3:0] Pos_men;
  logic [3:0] rule_idx;
  seq_state_t dbg_state;

  modport master (
    output start,
    input  busy, done, acc_clr, sel_2, sel_1, Mux_8Canais, Pos_men, rule_idx, dbg_state
  );

  modport slave (
    input  start,
    output busy, done, acc_clr, sel_2, sel_1, Mux_8Canais, Pos_men, rule_idx, dbg_state
  );

endinterface

// File: rtl/rule_sequencer_rule_table.sv
// Nine-entry consequent lookup indexed by rule number, combinational read.
// With RULE_TABLE_PROG_EN defined the table is a writable register file
// that resets to the default table; otherwise it is the hardwired default.
module rule_table
  import rule_seq_pkg::*;
(
`ifdef RULE_TABLE_PROG_EN
  input  logic       clk,
  input  logic       rst,
  input  logic       i_we,
  input  logic [3:0] i_wr_addr,
  input  logic [1:0] i_wr_data,
`endif
  input  logic [3:0] i_rd_addr,
  output logic [1:0] o_rd_data
);

`ifdef RULE_TABLE_PROG_EN
  logic [1:0] r_tab [NUM_RULES];
  logic [1:0] w_wr_val;
  logic       w_wr_ok;

  // Code 3 has no output register behind it, so it is stored as saida_2.
  assign w_wr_val = (i_wr_data == 2'd3) ? 2'd2 : i_wr_data;
  assign w_wr_ok  = i_we && (i_wr_addr < 4'(NUM_RULES));

  // Register file: reset to the default table, single write port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_RULES; k++) r_tab[k] <= default_cons(4'(k));
    end else if (w_wr_ok) begin
      r_tab[i_wr_addr] <= w_wr_val;
    end
  end

  assign o_rd_data = (i_rd_addr < 4'(NUM_RULES)) ? r_tab[i_rd_addr] : 2'd0;
`else
  assign o_rd_data = default_cons(i_rd_addr);
`endif

endmodule

// File: rtl/rule_sequencer.sv
// Rule sequencer for the 3x3 fuzzy rule base. Walks rules 0..8, holding each
// for STALL+1 cycles, driving antecedent selects, the max-feedback select and
// a one-hot write strobe on the last hold cycle. Every output is registered:
// the next-state logic also computes the outputs for the next state.
// Optional feature macro: RULE_TABLE_PROG_EN (programmable consequent table).
module rule_sequencer
  import rule_seq_pkg::*;
#(
  parameter int unsigned STALL = 0
)(
  input  logic clk,
  input  logic rst,
`ifdef RULE_TABLE_PROG_EN
  input  logic       cfg_we,
  input  logic [3:0] cfg_addr,
  input  logic [1:0] cfg_data,
`endif
  rule_sequencer_if.slave bus
);

  localparam logic [2:0] STALL_L  = STALL[2:0];
  localparam logic [1:0] LAST_SET = 2'(NUM_SETS - 1);

  seq_state_t r_state, w_state_nxt;
  logic [1:0] r_i, r_j, w_i_nxt, w_j_nxt;
  logic [2:0] r_h, w_h_nxt;

  logic [3:0] w_rule_nxt;
  logic [1:0] w_cons_nxt;

  logic       r_busy, r_done, r_acc_clr;
  logic [1:0] r_sel_2, r_sel_1, r_mux;
  logic [3:0] r_pos_men, r_rule_idx;

  logic       w_busy_nxt, w_done_nxt, w_acc_clr_nxt;
  logic [1:0] w_sel_2_nxt, w_sel_1_nxt, w_mux_nxt;
  logic [3:0] w_pos_men_nxt, w_rule_idx_nxt;

  // Consequent lookup for the rule that will be presented next cycle.
  assign w_rule_nxt = rule_num(w_i_nxt, w_j_nxt);

`ifdef RULE_TABLE_PROG_EN
  logic w_cfg_we;
  // Table edits are only accepted while no pass is in flight.
  assign w_cfg_we = cfg_we && (r_state == ST_IDLE);

  rule_table u_rule_table (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_cfg_we),
    .i_wr_addr (cfg_addr),
    .i_wr_data (cfg_data),
    .i_rd_addr (w_rule_nxt),
    .o_rd_data (w_cons_nxt)
  );
`else
  rule_table u_rule_table (
    .i_rd_addr (w_rule_nxt),
    .o_rd_data (w_cons_nxt)
  );
`endif

  // Next state and rule/hold counters.
  always_comb begin
    w_state_nxt = r_state;
    w_i_nxt     = r_i;
    w_j_nxt     = r_j;
    w_h_nxt     = r_h;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) w_state_nxt = ST_CLR;
      end
      ST_CLR: begin
        w_state_nxt = ST_RUN;
        w_i_nxt     = 2'd0;
        w_j_nxt     = 2'd0;
        w_h_nxt     = 3'd0;
      end
      ST_RUN: begin
        if (r_h != STALL_L) begin
          w_h_nxt = r_h + 3'd1;
        end else begin
          w_h_nxt = 3'd0;
          if (r_j == LAST_SET) begin
            w_j_nxt = 2'd0;
            if (r_i == LAST_SET) begin
              w_i_nxt     = 2'd0;
              w_state_nxt = ST_DONE;
            end else begin
              w_i_nxt = r_i + 2'd1;
            end
          end else begin
            w_j_nxt = r_j + 2'd1;
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Moore outputs for the state being entered; registered below.
  always_comb begin
    w_busy_nxt     = 1'b0;
    w_done_nxt     = 1'b0;
    w_acc_clr_nxt  = 1'b0;
    w_sel_2_nxt    = 2'd0;
    w_sel_1_nxt    = 2'd0;
    w_mux_nxt      = 2'd0;
    w_pos_men_nxt  = POS_NONE;
    w_rule_idx_nxt = 4'd0;
    case (w_state_nxt)
      ST_CLR: begin
        w_busy_nxt    = 1'b1;
        w_acc_clr_nxt = 1'b1;
      end
      ST_RUN: begin
        w_busy_nxt     = 1'b1;
        w_sel_2_nxt    = w_i_nxt;
        w_sel_1_nxt    = w_j_nxt;
        w_mux_nxt      = w_cons_nxt;
        w_rule_idx_nxt = w_rule_nxt;
        // Write only on the last hold cycle so the min/max path has settled.
        if (w_h_nxt == STALL_L) w_pos_men_nxt = pos_onehot(w_cons_nxt);
      end
      ST_DONE: begin
        w_done_nxt = 1'b1;
      end
      default: begin
        w_busy_nxt = 1'b0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_i     <= 2'd0;
      r_j     <= 2'd0;
      r_h     <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_i     <= w_i_nxt;
      r_j     <= w_j_nxt;
      r_h     <= w_h_nxt;
    end
  end

  // Output registers; reset clears them so an aborted pass leaves no strobe or done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_acc_clr  <= 1'b0;
      r_sel_2    <= 2'd0;
      r_sel_1    <= 2'd0;
      r_mux      <= 2'd0;
      r_pos_men  <= POS_NONE;
      r_rule_idx <= 4'd0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_acc_clr  <= w_acc_clr_nxt;
      r_sel_2    <= w_sel_2_nxt;
      r_sel_1    <= w_sel_1_nxt;
      r_mux      <= w_mux_nxt;
      r_pos_men  <= w_pos_men_nxt;
      r_rule_idx <= w_rule_idx_nxt;
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.acc_clr     = r_acc_clr;
  assign bus.sel_2       = r_sel_2;
  assign bus.sel_1       = r_sel_1;
  assign bus.Mux_8Canais = r_mux;
  assign bus.Pos_men     = r_pos_men;
  assign bus.rule_idx    = r_rule_idx;
  assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_rule_sequencer.sv
// Bench for rule_sequencer: two instances (STALL=0 and STALL=2) share clock,
// reset and table-config inputs. A pass-level reference model builds the
// expected per-cycle output trace of each pass; directed sequences cover the
// timing corners, and a behavioural rule unit checks the integration results.
module tb_rule_sequencer;
  import rule_seq_pkg::*;

  logic clk;
  logic rst;
  logic       cfg_we;
  logic [3:0] cfg_addr;
  logic [1:0] cfg_data;

  rule_sequencer_if ifc0();
  rule_sequencer_if ifc2();

  rule_sequencer #(.STALL(0)) dut0 (
    .clk      (clk),
    .rst      (rst),
`ifdef RULE_TABLE_PROG_EN
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
`endif
    .bus      (ifc0)
  );

  rule_sequencer #(.STALL(2)) dut2 (
    .clk      (clk),
    .rst      (rst),
`ifdef RULE_TABLE_PROG_EN
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
`endif
    .bus      (ifc2)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed word: {busy, done, acc_clr, sel_2, sel_1, mux, pos_men, rule_idx}
  logic [16:0] act0, act2;
  assign act0 = {ifc0.busy, ifc0.done, ifc0.acc_clr, ifc0.sel_2, ifc0.sel_1,
                 ifc0.Mux_8Canais, ifc0.Pos_men, ifc0.rule_idx};
  assign act2 = {ifc2.busy, ifc2.done, ifc2.acc_clr, ifc2.sel_2, ifc2.sel_1,
                 ifc2.Mux_8Canais, ifc2.Pos_men, ifc2.rule_idx};

  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------- reference model ----------------
  // Default table from the rule: c = 0 if i+j<=1, 1 if i+j==2, 2 otherwise.
  function automatic logic [17:0] ref_default_tab();
    logic [17:0] t;
    int s;
    t = '0;
    for (int r = 0; r < 9; r++) begin
      s = r / 3 + r % 3;
      t[2*r +: 2] = (s <= 1) ? 2'd0 : ((s == 2) ? 2'd1 : 2'd2);
    end
    return t;
  endfunction

  // n-th cycle of a pass after the accepting start edge: CLR, 9*(s+1) rule cycles, DONE.
  function automatic logic [16:0] trace_word(input int s, input int n, input logic [17:0] tab);
    int r, h;
    logic [1:0] c;
    logic [3:0] pm;
    if (n == 0) return {1'b1, 1'b0, 1'b1, 14'd0};
    if (n == 9 * (s + 1) + 1) return {1'b0, 1'b1, 1'b0, 14'd0};
    r  = (n - 1) / (s + 1);
    h  = (n - 1) % (s + 1);
    c  = tab[2*r +: 2];
    pm = (h == s) ? (4'b0001 << c) : 4'b0000;
    return {1'b1, 1'b0, 1'b0, 2'(r / 3), 2'(r % 3), c, pm, 4'(r)};
  endfunction

  logic [16:0] exp_q0[$];
  logic [16:0] exp_q2[$];
  logic [16:0] cur0 = '0;
  logic [16:0] cur2 = '0;
  logic [17:0] tab0, tab2;

  // A sequencer is idle exactly when every observed output is zero.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q0.delete(); exp_q2.delete();
      cur0 = '0; cur2 = '0;
      tab0 = ref_default_tab(); tab2 = ref_default_tab();
    end else begin
      if (cur0 == '0) begin
`ifdef RULE_TABLE_PROG_EN
        if (cfg_we && cfg_addr < 4'd9) tab0[2*int'(cfg_addr) +: 2] = (cfg_data == 2'd3) ? 2'd2 : cfg_data;
`endif
        if (ifc0.start) for (int n = 0; n < 11; n++) exp_q0.push_back(trace_word(0, n, tab0));
      end
      if (cur2 == '0) begin
`ifdef RULE_TABLE_PROG_EN
        if (cfg_we && cfg_addr < 4'd9) tab2[2*int'(cfg_addr) +: 2] = (cfg_data == 2'd3) ? 2'd2 : cfg_data;
`endif
        if (ifc2.start) for (int n = 0; n < 29; n++) exp_q2.push_back(trace_word(2, n, tab2));
      end
      cur0 = (exp_q0.size() > 0) ? exp_q0.pop_front() : '0;
      cur2 = (exp_q2.size() > 0) ? exp_q2.pop_front() : '0;
    end
  end

  // ---------------- behavioural rule unit on dut0 ----------------
  logic [7:0] fou_a [4];   // FOU_01..03 selected by sel_2
  logic [7:0] fou_b [4];   // FOU_04..06 selected by sel_1
  logic [7:0] saida [4];
  logic [7:0] ru_min, ru_val;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 4; k++) saida[k] <= 8'h00;
    end else if (ifc0.acc_clr) begin
      for (int k = 0; k < 4; k++) saida[k] <= 8'h00;
    end else if (ifc0.Pos_men != 4'b0000) begin
      ru_min = (fou_a[ifc0.sel_2] < fou_b[ifc0.sel_1]) ? fou_a[ifc0.sel_2] : fou_b[ifc0.sel_1];
      ru_val = (ru_min > saida[ifc0.Mux_8Canais]) ? ru_min : saida[ifc0.Mux_8Canais];
      case (ifc0.Pos_men)
        4'b0001: saida[0] <= ru_val;
        4'b0010: saida[1] <= ru_val;
        4'b0100: saida[2] <= ru_val;
        default: saida[3] <= ru_val;
      endcase
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to the next falling edge and compare both instances against the model.
  task automatic tick();
    @(negedge clk);
    check("sb_stall0", 32'(act0), 32'(cur0));
    check("sb_stall2", 32'(act2), 32'(cur2));
  endtask

  // Drive a one-cycle start on dut0; returns in the cycle after the start edge.
  task automatic pulse0();
    ifc0.start = 1'b1;
    tick();
    ifc0.start = 1'b0;
  endtask

  task automatic wait_done0(input string name);
    int c;
    c = 0;
    while (!ifc0.done && c < 60) begin tick(); c++; end
    check(name, 32'(ifc0.done), 32'd1);
  endtask

  typedef struct {
    logic [1:0] i;
    logic [1:0] j;
    logic [1:0] mux;
    logic [3:0] pos;
  } vec_t;
  vec_t vecs [9];

  // ---------------- main sequence ----------------
  initial begin
    int c, pc, dn;
    vecs[0] = '{2'd0, 2'd0, 2'd0, 4'b0001};
    vecs[1] = '{2'd0, 2'd1, 2'd0, 4'b0001};
    vecs[2] = '{2'd0, 2'd2, 2'd1, 4'b0010};
    vecs[3] = '{2'd1, 2'd0, 2'd0, 4'b0001};
    vecs[4] = '{2'd1, 2'd1, 2'd1, 4'b0010};
    vecs[5] = '{2'd1, 2'd2, 2'd2, 4'b0100};
    vecs[6] = '{2'd2, 2'd0, 2'd1, 4'b0010};
    vecs[7] = '{2'd2, 2'd1, 2'd2, 4'b0100};
    vecs[8] = '{2'd2, 2'd2, 2'd2, 4'b0100};

    rst = 1'b0; ifc0.start = 1'b0; ifc2.start = 1'b0;
    cfg_we = 1'b0; cfg_addr = 4'd0; cfg_data = 2'd0;
    for (int k = 0; k < 4; k++) begin fou_a[k] = 8'h80; fou_b[k] = 8'h80; end

    repeat (3) tick();
    check("reset_out0", 32'(act0), 32'd0);
    check("reset_out2", 32'(act2), 32'd0);
    check("reset_state0", 32'(ifc0.dbg_state), 32'(ST_IDLE));
    rst = 1'b1;
    repeat (2) tick();

    // STALL=0 pass, table-driven, with all FOUs at 0x80.
    pulse0();
    check("clr_cycle", 32'({ifc0.busy, ifc0.acc_clr, ifc0.Pos_men}), 32'({1'b1, 1'b1, 4'b0000}));
    for (int r = 0; r < 9; r++) begin
      tick();
      check($sformatf("rule%0d_out", r),
            32'({ifc0.sel_2, ifc0.sel_1, ifc0.Mux_8Canais, ifc0.Pos_men}),
            32'({vecs[r].i, vecs[r].j, vecs[r].mux, vecs[r].pos}));
    end
    tick();
    check("done_k11", 32'({ifc0.busy, ifc0.done}), 32'({1'b0, 1'b1}));
    check("saida_all_80", 32'({saida[0], saida[1], saida[2]}), 32'({8'h80, 8'h80, 8'h80}));
    tick();

    // Integration: only FOU_03 and FOU_06 high.
    for (int k = 0; k < 4; k++) begin fou_a[k] = 8'h00; fou_b[k] = 8'h00; end
    fou_a[2] = 8'hFF; fou_b[2] = 8'hFF;
    pulse0();
    repeat (10) tick();
    check("done_pass2", 32'(ifc0.done), 32'd1);
    check("saida_ff_case", 32'({saida[0], saida[1], saida[2]}), 32'({8'h00, 8'h00, 8'hFF}));
    tick();

    // STALL=2: latency and strobe count.
    ifc2.start = 1'b1; tick(); ifc2.start = 1'b0;
    c = 1; pc = 0;
    while (!ifc2.done && c < 100) begin
      tick(); c++;
      if (ifc2.Pos_men != 4'b0000) pc++;
    end
    check("stall2_latency", 32'(c), 32'd29);
    check("stall2_strobes", 32'(pc), 32'd9);
    tick();

    // start re-pulsed during RUN and in the DONE cycle is ignored.
    pulse0();
    repeat (3) tick();
    pulse0();
    c = 5;
    while (!ifc0.done && c < 60) begin tick(); c++; end
    check("ignore_run_start", 32'(c), 32'd11);
    pulse0();
    check("ignore_done_start", 32'({ifc0.busy, ifc0.acc_clr}), 32'd0);
    tick();
    pulse0();
    check("idle_start_accepted", 32'({ifc0.busy, ifc0.acc_clr}), 32'({1'b1, 1'b1}));
    wait_done0("pass_after_ignore");
    tick();

    // Reset during rule 4: outputs drop at once, no done, next pass from rule 0.
    pulse0();
    repeat (5) tick();
    check("at_rule4", 32'(ifc0.rule_idx), 32'd4);
    #2 rst = 1'b0;
    #1 check("reset_midpass", 32'(act0), 32'd0);
    tick();
    rst = 1'b1;
    dn = 0;
    repeat (12) begin tick(); if (ifc0.done) dn++; end
    check("no_done_after_abort", 32'(dn), 32'd0);
    pulse0();
    tick();
    check("restart_rule0", 32'({ifc0.busy, ifc0.rule_idx, ifc0.sel_2, ifc0.sel_1}), 32'({1'b1, 4'd0, 2'd0, 2'd0}));
    wait_done0("restart_done");
    tick();

`ifdef RULE_TABLE_PROG_EN
    // Program rule 4 to consequent 0 and rule 0 to code 3 (stored as 2).
    cfg_we = 1'b1; cfg_addr = 4'd4; cfg_data = 2'd0; tick();
    cfg_addr = 4'd0; cfg_data = 2'd3; tick();
    cfg_we = 1'b0;
    pulse0();
    tick();
    check("prog_rule0", 32'({ifc0.Mux_8Canais, ifc0.Pos_men}), 32'({2'd2, 4'b0100}));
    repeat (4) tick();
    check("prog_rule4", 32'({ifc0.rule_idx, ifc0.Mux_8Canais, ifc0.Pos_men}), 32'({4'd4, 2'd0, 4'b0001}));
    wait_done0("prog_done");
    tick();
    // Writes mid-pass (dut0 busy) and to an out-of-range address.
    pulse0();
    repeat (2) tick();
    cfg_we = 1'b1; cfg_addr = 4'd4; cfg_data = 2'd2; tick();
    cfg_we = 1'b0;
    wait_done0("midwrite_done");
    tick();
    pulse0();
    repeat (5) tick();
    check("midwrite_dropped", 32'({ifc0.rule_idx, ifc0.Mux_8Canais, ifc0.Pos_men}), 32'({4'd4, 2'd0, 4'b0001}));
    wait_done0("midwrite_pass2_done");
    tick();
`endif

    // Randomized traffic against the model.
    for (int k = 0; k < 4; k++) begin fou_a[k] = 8'($urandom_range(0, 255)); fou_b[k] = 8'($urandom_range(0, 255)); end
    for (int n = 0; n < 2000; n++) begin
      ifc0.start = ($urandom_range(0, 7) == 0);
      ifc2.start = ($urandom_range(0, 15) == 0);
      cfg_we   = ($urandom_range(0, 5) == 0);
      cfg_addr = 4'($urandom_range(0, 15));
      cfg_data = 2'($urandom_range(0, 3));
      rst      = ($urandom_range(0, 299) != 0);
      tick();
    end
    ifc0.start = 1'b0; ifc2.start = 1'b0; cfg_we = 1'b0; rst = 1'b1;
    repeat (40) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
